// File: rtl/rgen_host_arbiter.sv
// Two-requester round-robin arbiter onto one register-access port; holds one command until response or abort.
// Latency: request to o_command_valid 1 cycle; response strobe is combinational from i_response_ready.
// Optional busy watchdog: define RGEN_HOST_ARBITER_TIMEOUT_EN to force an error response after TIMEOUT_CYCLES.
module rgen_host_arbiter #(
    parameter int DATA_WIDTH          = 32,
    parameter int LOCAL_ADDRESS_WIDTH = 16,
    parameter int TIMEOUT_CYCLES      = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       i_command_valid,
    input  logic [1:0]                       i_write,
    input  logic [1:0]                       i_read,
    input  logic [2*LOCAL_ADDRESS_WIDTH-1:0] i_address,
    input  logic [2*DATA_WIDTH-1:0]          i_write_data,
    input  logic [2*DATA_WIDTH-1:0]          i_write_mask,
    output logic [1:0]                       o_response_ready,
    output logic [DATA_WIDTH-1:0]            o_read_data,
    output logic [3:0]                       o_status,
    output logic [1:0]                       o_grant,
    output logic                             o_command_valid,
    output logic                             o_write,
    output logic                             o_read,
    output logic [LOCAL_ADDRESS_WIDTH-1:0]   o_address,
    output logic [DATA_WIDTH-1:0]            o_write_data,
    output logic [DATA_WIDTH-1:0]            o_write_mask,
    input  logic                             i_response_ready,
    input  logic [DATA_WIDTH-1:0]            i_read_data,
    input  logic [1:0]                       i_status
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]                     r_state;
    logic                           r_ptr;
    logic [1:0]                     r_grant;
    logic                           r_command_valid;
    logic                           r_write;
    logic                           r_read;
    logic [LOCAL_ADDRESS_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0]          r_write_data;
    logic [DATA_WIDTH-1:0]          r_write_mask;

    logic                           w_busy;
    logic                           w_owner;
    logic                           w_sel;
    logic                           w_abort;
    logic                           w_timeout;
    logic                           w_done;
    logic [1:0]                     w_rsp_status;
    logic [LOCAL_ADDRESS_WIDTH-1:0] w_sel_address;
    logic [DATA_WIDTH-1:0]          w_sel_write_data;
    logic [DATA_WIDTH-1:0]          w_sel_write_mask;

    assign w_busy  = (r_state == ST_BUSY);
    assign w_owner = r_grant[1];

    // The pointer only matters under contention; a lone requester always wins.
    assign w_sel = (i_command_valid == 2'b11) ? r_ptr : i_command_valid[1];

    assign w_sel_address    = w_sel ? i_address[LOCAL_ADDRESS_WIDTH +: LOCAL_ADDRESS_WIDTH]
                                    : i_address[0 +: LOCAL_ADDRESS_WIDTH];
    assign w_sel_write_data = w_sel ? i_write_data[DATA_WIDTH +: DATA_WIDTH]
                                    : i_write_data[0 +: DATA_WIDTH];
    assign w_sel_write_mask = w_sel ? i_write_mask[DATA_WIDTH +: DATA_WIDTH]
                                    : i_write_mask[0 +: DATA_WIDTH];

    // Owner withdrawing its request wins over any response arriving in the same cycle.
    assign w_abort = w_busy & ~i_command_valid[w_owner];
    assign w_done  = w_busy & ~w_abort & (i_response_ready | w_timeout);

`ifdef RGEN_HOST_ARBITER_TIMEOUT_EN
    logic [15:0] r_busy_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_cnt <= 16'd0;
        end else if (!w_busy) begin
            r_busy_cnt <= 16'd0;
        end else if (!i_response_ready) begin
            r_busy_cnt <= r_busy_cnt + 16'd1;
        end
    end

    // Count is zero in the first busy cycle, so the limit is hit on busy cycle TIMEOUT_CYCLES.
    assign w_timeout = w_busy & ~w_abort & ~i_response_ready
                     & (r_busy_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign w_timeout            = 1'b0;
`endif

    always_comb begin
        w_rsp_status     = 2'b00;
        o_read_data      = '0;
        o_status         = 4'b0000;
        o_response_ready = 2'b00;
        if (w_busy) begin
            w_rsp_status     = w_timeout ? 2'b11 : i_status;
            o_read_data      = w_timeout ? '0 : i_read_data;
            o_status         = w_owner ? {w_rsp_status, 2'b00} : {2'b00, w_rsp_status};
            o_response_ready = w_owner ? {w_done, 1'b0} : {1'b0, w_done};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_ptr           <= 1'b0;
            r_grant         <= 2'b00;
            r_command_valid <= 1'b0;
            r_write         <= 1'b0;
            r_read          <= 1'b0;
            r_address       <= '0;
            r_write_data    <= '0;
            r_write_mask    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|i_command_valid) begin
                        r_state         <= ST_BUSY;
                        r_grant         <= w_sel ? 2'b10 : 2'b01;
                        r_command_valid <= 1'b1;
                        r_write         <= i_write[w_sel];
                        r_read          <= i_read[w_sel];
                        r_address       <= w_sel_address;
                        r_write_data    <= w_sel_write_data;
                        r_write_mask    <= w_sel_write_mask;
                    end
                end
                ST_BUSY: begin
                    if (w_abort || w_done) begin
                        r_state         <= ST_IDLE;
                        r_grant         <= 2'b00;
                        r_command_valid <= 1'b0;
                        r_write         <= 1'b0;
                        r_read          <= 1'b0;
                        r_address       <= '0;
                        r_write_data    <= '0;
                        r_write_mask    <= '0;
                        if (w_done) begin
                            r_ptr <= ~w_owner;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_grant         = r_grant;
    assign o_command_valid = r_command_valid;
    assign o_write         = r_write;
    assign o_read          = r_read;
    assign o_address       = r_address;
    assign o_write_data    = r_write_data;
    assign o_write_mask    = r_write_mask;

endmodule

// File: tb/tb_rgen_host_arbiter.sv
// Scoreboarded random bench for rgen_host_arbiter: driver queues expected responses, monitor pops on o_response_ready.
module tb_rgen_host_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int TB_TO = 4;
`ifdef RGEN_HOST_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    i_command_valid;
    logic [1:0]    i_write;
    logic [1:0]    i_read;
    logic [2*AW-1:0] i_address;
    logic [2*DW-1:0] i_write_data;
    logic [2*DW-1:0] i_write_mask;
    logic [1:0]    o_response_ready;
    logic [DW-1:0] o_read_data;
    logic [3:0]    o_status;
    logic [1:0]    o_grant;
    logic          o_command_valid;
    logic          o_write;
    logic          o_read;
    logic [AW-1:0] o_address;
    logic [DW-1:0] o_write_data;
    logic [DW-1:0] o_write_mask;
    logic          i_response_ready;
    logic [DW-1:0] i_read_data;
    logic [1:0]    i_status;

    always #5 clk = ~clk;

    rgen_host_arbiter #(
        .DATA_WIDTH(DW),
        .LOCAL_ADDRESS_WIDTH(AW),
        .TIMEOUT_CYCLES(TB_TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_command_valid(i_command_valid),
        .i_write(i_write),
        .i_read(i_read),
        .i_address(i_address),
        .i_write_data(i_write_data),
        .i_write_mask(i_write_mask),
        .o_response_ready(o_response_ready),
        .o_read_data(o_read_data),
        .o_status(o_status),
        .o_grant(o_grant),
        .o_command_valid(o_command_valid),
        .o_write(o_write),
        .o_read(o_read),
        .o_address(o_address),
        .o_write_data(o_write_data),
        .o_write_mask(o_write_mask),
        .i_response_ready(i_response_ready),
        .i_read_data(i_read_data),
        .i_status(i_status)
    );

    typedef struct {
        logic [1:0]    rdy;
        logic [3:0]    status;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int n_checks = 0;
    int n_fail = 0;
    int model_ptr = 0;

    logic          wr_f[2];
    logic          rd_f[2];
    logic [AW-1:0] addr_f[2];
    logic [DW-1:0] data_f[2];
    logic [DW-1:0] mask_f[2];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    task automatic randomize_fields();
        for (int r = 0; r < 2; r++) begin
            wr_f[r]   = 1'($urandom_range(0, 1));
            rd_f[r]   = ~wr_f[r];
            addr_f[r] = 16'($urandom);
            data_f[r] = $urandom;
            mask_f[r] = $urandom;
        end
    endtask

    task automatic drive_fields();
        i_write      = {wr_f[1], wr_f[0]};
        i_read       = {rd_f[1], rd_f[0]};
        i_address    = {addr_f[1], addr_f[0]};
        i_write_data = {data_f[1], data_f[0]};
        i_write_mask = {mask_f[1], mask_f[0]};
    endtask

    task automatic scramble_ports();
        i_write      = 2'($urandom);
        i_read       = 2'($urandom);
        i_address    = $urandom;
        i_write_data = {$urandom, $urandom};
        i_write_mask = {$urandom, $urandom};
    endtask

    // Called just after a rising edge; returns just after the edge that ends the transaction.
    task automatic run_txn(input logic [1:0] vm, input int delay, input bit do_abort, input int abort_at,
                           input bit fix_rsp, input logic [1:0] fst, input logic [DW-1:0] fdat);
        int win;
        int outcome;
        bit tmo;
        logic [1:0] oh;
        logic e_wr, e_rd;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data, e_mask;
        exp_t e;
        win    = (vm == 2'b11) ? model_ptr : (vm[1] ? 1 : 0);
        oh     = (win == 1) ? 2'b10 : 2'b01;
        e_wr   = wr_f[win];
        e_rd   = rd_f[win];
        e_addr = addr_f[win];
        e_data = data_f[win];
        e_mask = mask_f[win];
        i_command_valid  = vm;
        drive_fields();
        i_response_ready = 1'($urandom_range(0, 1));
        i_status         = 2'($urandom);
        i_read_data      = $urandom;
        @(negedge clk);
        chk("idle_cmd_valid", 64'(o_command_valid), 64'd0);
        chk("idle_grant", 64'(o_grant), 64'd0);
        chk("idle_status", 64'(o_status), 64'd0);
        chk("idle_rdata", 64'(o_read_data), 64'd0);
        @(posedge clk); #1;
        i_response_ready = 1'b0;
        outcome = 0;
        for (int k = 1; k <= 16 && outcome == 0; k++) begin
            tmo = 1'b0;
            scramble_ports();
            i_status    = fix_rsp ? fst : 2'($urandom);
            i_read_data = fix_rsp ? fdat : $urandom;
            if (do_abort && k == abort_at) begin
                i_command_valid = 2'b00;
                outcome = 1;
            end else if (TO_EN && k == TB_TO) begin
                tmo     = 1'b1;
                e.rdy   = oh;
                e.status = (win == 1) ? 4'b1100 : 4'b0011;
                e.rdata = '0;
                sb_q.push_back(e);
                outcome = 2;
            end else if (k == delay + 1) begin
                i_response_ready = 1'b1;
                e.rdy    = oh;
                e.status = (win == 1) ? {i_status, 2'b00} : {2'b00, i_status};
                e.rdata  = i_read_data;
                sb_q.push_back(e);
                outcome = 2;
            end
            @(negedge clk);
            chk("busy_cmd_valid", 64'(o_command_valid), 64'd1);
            chk("busy_grant", 64'(o_grant), 64'(oh));
            chk("busy_write", 64'(o_write), 64'(e_wr));
            chk("busy_read", 64'(o_read), 64'(e_rd));
            chk("busy_addr", 64'(o_address), 64'(e_addr));
            chk("busy_wdata", 64'(o_write_data), 64'(e_data));
            chk("busy_wmask", 64'(o_write_mask), 64'(e_mask));
            if (!tmo) begin
                chk("busy_status", 64'(o_status),
                    64'((win == 1) ? {i_status, 2'b00} : {2'b00, i_status}));
                chk("busy_rdata", 64'(o_read_data), 64'(i_read_data));
            end
            @(posedge clk); #1;
            i_response_ready = 1'b0;
        end
        if (outcome == 2) model_ptr = 1 - win;
        chk("resp_missing", 64'(sb_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && o_response_ready != 2'b00) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp actual=%b required=00", o_response_ready);
            end else begin
                mon_e = sb_q.pop_front();
                chk("resp_ready", 64'(o_response_ready), 64'(mon_e.rdy));
                chk("resp_status", 64'(o_status), 64'(mon_e.status));
                chk("resp_rdata", 64'(o_read_data), 64'(mon_e.rdata));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] vm;
        int dly, abat;
        bit ab;
        i_command_valid  = 2'b00;
        i_write          = 2'b00;
        i_read           = 2'b00;
        i_address        = '0;
        i_write_data     = '0;
        i_write_mask     = '0;
        i_response_ready = 1'b0;
        i_read_data      = '0;
        i_status         = 2'b00;
        rst              = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_valid", 64'(o_command_valid), 64'd0);
        chk("rst_grant", 64'(o_grant), 64'd0);
        chk("rst_write", 64'(o_write), 64'd0);
        chk("rst_read", 64'(o_read), 64'd0);
        chk("rst_addr", 64'(o_address), 64'd0);
        chk("rst_wdata", 64'(o_write_data), 64'd0);
        chk("rst_wmask", 64'(o_write_mask), 64'd0);
        chk("rst_resp", 64'(o_response_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_ptr = 0;

        // contention after reset: requester 0, then requester 1
        randomize_fields(); run_txn(2'b11, 1, 1'b0, 0, 1'b0, 2'b00, '0);
        randomize_fields(); run_txn(2'b11, 0, 1'b0, 0, 1'b0, 2'b00, '0);

        randomize_fields();
        wr_f[0] = 1'b1; rd_f[0] = 1'b0; addr_f[0] = 16'h0010;
        data_f[0] = 32'hA5A5A5A5; mask_f[0] = 32'hFFFFFFFF;
        run_txn(2'b01, 2, 1'b0, 0, 1'b0, 2'b00, '0);

        randomize_fields();
        wr_f[1] = 1'b0; rd_f[1] = 1'b1;
        run_txn(2'b10, 1, 1'b0, 0, 1'b1, 2'b01, 32'h12345678);

        // abort by requester 1, then contention shows the pointer did not move
        randomize_fields(); run_txn(2'b10, 3, 1'b1, 2, 1'b0, 2'b00, '0);
        randomize_fields(); run_txn(2'b11, 0, 1'b0, 0, 1'b0, 2'b00, '0);

        // long wait: times out on busy cycle 4 when the watchdog is built in
        randomize_fields(); run_txn(2'b01, 8, 1'b0, 0, 1'b0, 2'b00, '0);

        for (int n = 0; n < 150; n++) begin
            randomize_fields();
            vm   = 2'($urandom_range(1, 3));
            dly  = $urandom_range(0, 5);
            ab   = ($urandom_range(0, 5) == 0);
            abat = $urandom_range(1, (dly + 1 > TB_TO) ? TB_TO : dly + 1);
            run_txn(vm, dly, ab, abat, 1'b0, 2'b00, '0);
            if ($urandom_range(0, 3) == 0) begin
                i_command_valid = 2'b00;
                @(posedge clk); #1;
            end
        end

        // reset in the middle of a busy command owned by requester 1
        randomize_fields(); run_txn(2'b01, 0, 1'b0, 0, 1'b0, 2'b00, '0);
        randomize_fields();
        i_command_valid = 2'b11;
        drive_fields();
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_grant", 64'(o_grant), 64'd2);
        i_response_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("midrst_cmd_valid", 64'(o_command_valid), 64'd0);
        chk("midrst_grant", 64'(o_grant), 64'd0);
        chk("midrst_resp", 64'(o_response_ready), 64'd0);
        chk("midrst_status", 64'(o_status), 64'd0);
        chk("midrst_addr", 64'(o_address), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        i_response_ready = 1'b0;
        i_command_valid  = 2'b00;
        rst = 1'b0;
        model_ptr = 0;
        randomize_fields(); run_txn(2'b11, 1, 1'b0, 0, 1'b0, 2'b00, '0);

        i_command_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
